// File: rtl/uart_ctrl.sv
// Memory-mapped 8N1 UART: store transmits wdata[7:0], load pops the receive buffer.
// Define UART_RX_FIFO_EN for an RX_FIFO_DEPTH-entry receive FIFO instead of a single holding register.
module uart_ctrl #(
  parameter int CLKS_PER_BIT  = 434,
  parameter int RX_FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  uart_op_i,
  input  logic [31:0] uart_wdata_i,
  input  logic        stall_i,
  input  logic        rxd_i,
  output logic        txd_o,
  output logic [31:0] uart_rdata_o,
  output logic        data_ready_o,
  output logic        write_ready_o,
  output logic        rx_overrun_o
);

  localparam logic [3:0] MEM_NOP = 4'd0;
  localparam logic [3:0] MEM_LB  = 4'd1;
  localparam logic [3:0] MEM_LBU = 4'd2;
  localparam logic [3:0] MEM_LH  = 4'd3;
  localparam logic [3:0] MEM_LHU = 4'd4;
  localparam logic [3:0] MEM_LW  = 4'd5;
  localparam logic [3:0] MEM_SB  = 4'd6;
  localparam logic [3:0] MEM_SH  = 4'd7;
  localparam logic [3:0] MEM_SW  = 4'd8;

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_e;

  logic is_load, is_store, load_commit, store_commit;
  logic unused_ok;

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    case (uart_op_i)
      MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW: is_load  = 1'b1;
      MEM_SB, MEM_SH, MEM_SW:                   is_store = 1'b1;
      MEM_NOP:                                  ;
      default:                                  ;
    endcase
  end

  assign load_commit  = is_load & ~stall_i;
  assign store_commit = is_store & ~stall_i;
  assign unused_ok    = ^{uart_wdata_i[31:8], (RX_FIFO_DEPTH > 1)};

  // Transmitter
  state_e           tx_state_q;
  logic [CNT_W-1:0] tx_cnt_q;
  logic [2:0]       tx_bit_q;
  logic [7:0]       tx_shift_q;
  logic             txd_q;
  logic             tx_last;

  assign tx_last = (tx_cnt_q == BIT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= ST_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      txd_q      <= 1'b1;
    end else begin
      case (tx_state_q)
        ST_IDLE: begin
          if (store_commit) begin
            tx_state_q <= ST_START;
            tx_shift_q <= uart_wdata_i[7:0];
            tx_cnt_q   <= '0;
            txd_q      <= 1'b0;
          end
        end
        ST_START: begin
          if (tx_last) begin
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_state_q <= ST_DATA;
            txd_q      <= tx_shift_q[0];
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        ST_DATA: begin
          if (tx_last) begin
            tx_cnt_q   <= '0;
            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
            if (tx_bit_q == 3'd7) begin
              tx_state_q <= ST_STOP;
              txd_q      <= 1'b1;
            end else begin
              tx_bit_q <= tx_bit_q + 1'b1;
              txd_q    <= tx_shift_q[1];
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        ST_STOP: begin
          if (tx_last) begin
            tx_cnt_q   <= '0;
            tx_state_q <= ST_IDLE;
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        default: tx_state_q <= ST_IDLE;
      endcase
    end
  end

  // Receiver: 2-flop synchronizer, then mid-bit sampling
  state_e           rx_state_q;
  logic [CNT_W-1:0] rx_cnt_q;
  logic [2:0]       rx_bit_q;
  logic [7:0]       rx_shift_q;
  logic             rx_sync1_q, rx_sync2_q, rx_prev_q;
  logic             push_q;
  logic             rx_last;

  assign rx_last = (rx_cnt_q == BIT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q <= ST_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_sync1_q <= 1'b1;
      rx_sync2_q <= 1'b1;
      rx_prev_q  <= 1'b1;
      push_q     <= 1'b0;
    end else begin
      rx_sync1_q <= rxd_i;
      rx_sync2_q <= rx_sync1_q;
      rx_prev_q  <= rx_sync2_q;
      push_q     <= 1'b0;
      case (rx_state_q)
        ST_IDLE: begin
          if (rx_prev_q && !rx_sync2_q) begin
            rx_state_q <= ST_START;
            rx_cnt_q   <= '0;
          end
        end
        ST_START: begin
          if (rx_cnt_q == HALF_LAST) begin
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_state_q <= rx_sync2_q ? ST_IDLE : ST_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        ST_DATA: begin
          if (rx_last) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rx_sync2_q, rx_shift_q[7:1]};
            if (rx_bit_q == 3'd7) rx_state_q <= ST_STOP;
            else                  rx_bit_q   <= rx_bit_q + 1'b1;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        ST_STOP: begin
          // Leave at mid-stop so a back-to-back start edge is not missed
          if (rx_last) begin
            rx_cnt_q   <= '0;
            rx_state_q <= ST_IDLE;
            push_q     <= rx_sync2_q;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        default: rx_state_q <= ST_IDLE;
      endcase
    end
  end

  // Receive buffer
  logic       overrun_q, overrun_d;
  logic [7:0] head_byte;
  logic       pop;

`ifdef UART_RX_FIFO_EN
  localparam int AW = $clog2(RX_FIFO_DEPTH);

  logic [7:0]  fifo_q [RX_FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic        empty, full, push_ok;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop   = load_commit & ~empty;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    overrun_d = overrun_q;
    push_ok   = 1'b0;
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_q) begin
      if (full && !pop) begin
        overrun_d = 1'b1;
      end else begin
        push_ok  = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      overrun_q <= 1'b0;
      for (int i = 0; i < RX_FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      overrun_q <= overrun_d;
      if (push_ok) fifo_q[wr_ptr_q[AW-1:0]] <= rx_shift_q;
    end
  end

  assign head_byte    = fifo_q[rd_ptr_q[AW-1:0]];
  assign data_ready_o = ~empty;
`else
  logic [7:0] hold_q, hold_d;
  logic       valid_q, valid_d;

  assign pop = load_commit & valid_q;

  always_comb begin
    hold_d    = hold_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (pop) valid_d = 1'b0;
    if (push_q) begin
      if (valid_q && !pop) begin
        overrun_d = 1'b1;
      end else begin
        hold_d  = rx_shift_q;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign head_byte    = hold_q;
  assign data_ready_o = valid_q;
`endif

  assign txd_o         = txd_q;
  assign write_ready_o = (tx_state_q == ST_IDLE);
  assign rx_overrun_o  = overrun_q;
  assign uart_rdata_o  = {24'b0, head_byte};

endmodule
